// File: rtl/alu_mul_seq.sv
// Sequential unsigned 16x16 -> 32 multiplier that drives the shared 16-bit ALU
// through one ADD and one SHIFT cycle per multiplier bit.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] alu_r,
    output logic [15:0] alu_s,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_y,
    input  logic        alu_c
);

    localparam logic [3:0] OpNone  = 4'b0000;
    localparam logic [3:0] OpPassR = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0100;

    typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] acc_q;
    logic [15:0] mq_q;
    logic [15:0] mcand_q;
    logic        cy_q;
    logic [3:0]  cnt_q;
    logic [31:0] product_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        alu_op  = OpNone;
        alu_r   = 16'h0000;
        alu_s   = 16'h0000;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StAdd;
            end
            StAdd: begin
                alu_r   = acc_q;
                alu_s   = mcand_q;
                // A zero multiplier bit still runs the ALU, as pass-R with carry 0.
                alu_op  = mq_q[0] ? OpAdd : OpPassR;
                state_d = StShift;
            end
            StShift: begin
                state_d = (cnt_q == 4'd15) ? StDone : StAdd;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= 16'h0000;
            mq_q      <= 16'h0000;
            mcand_q   <= 16'h0000;
            cy_q      <= 1'b0;
            cnt_q     <= 4'd0;
            product_q <= 32'h0000_0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= 16'h0000;
                        mq_q    <= a;
                        mcand_q <= b;
                        cy_q    <= 1'b0;
                        cnt_q   <= 4'd0;
                    end
                end
                StAdd: begin
                    cy_q  <= alu_c;
                    acc_q <= alu_y;
                end
                StShift: begin
                    // Carry of the preceding add enters acc[15].
                    {cy_q, acc_q, mq_q} <= {1'b0, cy_q, acc_q, mq_q} >> 1;
                    if (cnt_q == 4'd15) begin
                        product_q <= {cy_q, acc_q, mq_q[15:1]};
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and random checks of alu_mul_seq against an attached combinational ALU model.
module tb_alu_mul_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic [3:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_c;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mul_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu_r   (alu_r),
        .alu_s   (alu_s),
        .alu_op  (alu_op),
        .alu_y   (alu_y),
        .alu_c   (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath ALU: add, pass R, otherwise zero.
    always_comb begin
        alu_y = 16'h0000;
        alu_c = 1'b0;
        case (alu_op)
            4'b0100: {alu_c, alu_y} = {1'b0, alu_r} + {1'b0, alu_s};
            4'b0001: alu_y = alu_r;
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call at a negedge. Issues one start, checks the 33 busy cycles, done and product.
    task automatic mul_op(input logic [15:0] av, input logic [15:0] bv, input bit chk_ops);
        logic [16:0] acc_m;
        logic [16:0] sum;
        int          bit_i;
        logic [31:0] exp_p;
        exp_p = av * bv;
        acc_m = 17'h0;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check_eq("busy_run", {31'b0, busy}, 32'd1);
            check_eq("done_early", {31'b0, done}, 32'd0);
            if (chk_ops) begin
                bit_i = k / 2;
                if (k % 2 == 0) begin
                    sum = {1'b0, acc_m[15:0]} + (av[bit_i] ? {1'b0, bv} : 17'h0);
                    check_eq("add_op", {28'b0, alu_op}, av[bit_i] ? 32'd4 : 32'd1);
                    check_eq("add_r", {16'b0, alu_r}, {16'b0, acc_m[15:0]});
                    check_eq("add_s", {16'b0, alu_s}, {16'b0, bv});
                    check_eq("add_c", {31'b0, alu_c}, {31'b0, sum[16]});
                    acc_m = sum >> 1;
                end else begin
                    check_eq("shift_op", {28'b0, alu_op}, 32'd0);
                    check_eq("shift_rs", {alu_r, alu_s}, 32'd0);
                end
            end
        end
        @(negedge clk);
        check_eq("done_pulse", {31'b0, done}, 32'd1);
        check_eq("busy_done", {31'b0, busy}, 32'd1);
        check_eq("product", product, exp_p);
        @(negedge clk);
        check_eq("done_clear", {31'b0, done}, 32'd0);
        check_eq("busy_clear", {31'b0, busy}, 32'd0);
        check_eq("product_hold", product, exp_p);
    endtask

    // Counts negedges until done is seen; scrambles a/b mid-operation when asked.
    task automatic wait_done(input bit scramble, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (scramble && busy) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        check_eq("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int n1;
        int n2;
        logic [15:0] ra;
        logic [15:0] rb;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        #3;
        check_eq("rst_busy_done", {30'b0, busy, done}, 32'd0);
        check_eq("rst_product", product, 32'd0);
        check_eq("rst_alu", {12'b0, alu_op, alu_r}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        mul_op(16'd3, 16'd5, 1'b1);
        @(negedge clk);
        mul_op(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        mul_op(16'h0000, 16'h1234, 1'b1);
        @(negedge clk);
        mul_op(16'h8001, 16'h0002, 1'b1);

        // Start held high; operands change during busy.
        @(negedge clk);
        start = 1'b1;
        a     = 16'd3;
        b     = 16'd5;
        @(posedge clk);
        #1;
        a = 16'hDEAD;
        b = 16'hBEEF;
        wait_done(1'b1, n1);
        check_eq("b2b_lat1", n1, 33);
        check_eq("b2b_prod1", product, 32'd15);
        a = 16'd7;
        b = 16'd9;
        wait_done(1'b1, n2);
        check_eq("b2b_gap", n2, 34);
        check_eq("b2b_prod2", product, 32'd63);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("b2b_idle", {31'b0, busy}, 32'd0);

        // Reset in the middle of an operation.
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy_done", {30'b0, busy, done}, 32'd0);
        check_eq("mid_rst_product", product, 32'd0);
        check_eq("mid_rst_alu", {12'b0, alu_op, alu_r}, 32'd0);
        check_eq("mid_rst_alu_s", {16'b0, alu_s}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_done", {31'b0, done}, 32'd0);
        end
        reset_n = 1'b1;
        mul_op(16'd7, 16'd9, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            @(negedge clk);
            mul_op(ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes an unsigned 16x16 → 32-bit product by driving the integer datapath's 16-bit ALU through a shift-add loop. Sits beside the ALU in the integer datapath. During a multiply it owns the ALU's R/S/opcode inputs and consumes its Y and carry outputs. Fixed latency, start/busy/done handshake to the instruction controller.

## Interface
- No parameters. Widths are fixed to the 16-bit datapath.
- clk  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  16  multiplier; captured on the accepting edge.
- b  in  16  multiplicand; captured on the accepting edge.
- busy  out  1  high from the accepting edge until return to IDLE.
- done  out  1  one-cycle pulse; product valid.
- product  out  32  result; held until the next accepted start.
- alu_r  out  16  drives ALU R input.
- alu_s  out  16  drives ALU S input.
- alu_op  out  4  drives ALU opcode.
- alu_y  in  16  ALU result.
- alu_c  in  1  ALU carry out.

## Operation
- Internal registers:
  - acc[15:0]: high partial product.
  - mq[15:0]: multiplier, becomes the low product.
  - mcand[15:0]: multiplicand.
  - cy: captured carry.
  - cnt[3:0]: bit counter.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE with start=1:
  - Load acc=0, mq=a, mcand=b, cy=0, cnt=0.
  - Go to ADD. busy=1 from this edge.
- ADD:
  - alu_r=acc, alu_s=mcand.
  - alu_op=4'b0100 (add) if mq[0]=1, else 4'b0001 (pass R, carry 0).
  - At the edge: {cy,acc}={alu_c,alu_y}. Go to SHIFT.
- SHIFT:
  - No ALU use; alu_op=4'b0000, alu_r=0, alu_s=0.
  - At the edge: {cy,acc,mq} <= {1'b0,cy,acc,mq} >> 1 (33-bit logical right shift; the carry enters acc[15]).
  - If cnt==15: go to DONE, else cnt+1 and go to ADD.
- DONE:
  - product={acc,mq}; done=1; busy=1.
  - At the edge: go to IDLE, busy=0.
- Outside ADD, ALU drives are alu_op=4'b0000, alu_r=16'h0000, alu_s=16'h0000.
- Width rules:
  - All arithmetic is unsigned.
  - The carry out of each add is never lost; it becomes bit 15 of acc after the shift.
  - Overflow of 32 bits is impossible: max 0xFFFF*0xFFFF=0xFFFE0001.
- start while busy (ADD, SHIFT or DONE) is ignored; there is no queuing. start must be reasserted in IDLE.
- a and b may change freely after the accepting edge.
- product updates only on the SHIFT→DONE edge. Its value is stable from the DONE cycle until the end of the next operation's final SHIFT.

## Timing
- Accepting edge is E0. Each bit takes one ADD and one SHIFT cycle: 16 bits = 32 cycles.
- DONE is entered on edge E32. done is high for exactly the cycle between E32 and E33.
- IDLE is re-entered on E33. The earliest next accepting edge is E34 (start sampled in IDLE).
- Throughput: one multiply per 34 cycles with start held high.
- ALU is treated as combinational. alu_y/alu_c must settle within the ADD cycle; no extra wait states.
- Reset (reset_n=0, any time, including mid-operation):
  - Immediately: state=IDLE, busy=0, done=0, product=0, acc=mq=mcand=0, cy=0, cnt=0, alu_op=0, alu_r=0, alu_s=0.
  - The first edge after deassertion can accept start.

## Test plan
- a=3, b=5, single start pulse:
  - done high exactly 33 cycles after the accepting edge; product=32'h0000000F; busy high for 33 cycles.
- a=16'hFFFF, b=16'hFFFF:
  - product=32'hFFFE0001; every ADD cycle shows alu_op=4'b0100.
  - The first ADD's alu_c=0; later ADDs produce carries that are absorbed correctly.
- a=16'h0000, b=16'h1234:
  - product=0; every ADD cycle shows alu_op=4'b0001, alu_r=acc, alu_s=16'h1234.
- a=16'h8001, b=16'h0002:
  - product=32'h00010002.
  - alu_op=4'b0100 in the ADD cycles for bit 0 and bit 15 only; 4'b0001 in the others.
- Ordering and back-to-back: start held high continuously with new a/b during busy.
  - Operands are captured only at IDLE edges.
  - Mid-operation a/b changes do not affect the product.
  - Accepting edges are 34 cycles apart.
- Reset and random regression:
  - reset_n pulsed low during cycle 10 of an operation: all outputs zero immediately, no done pulse. A new start after release gives the correct product (7*9=63).
  - 1000 random a/b pairs match a*b.
